// File: rtl/fifo_push_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_package
//   Shared definitions for the fifo block and its push-side arbiter.
//   DATA_WIDTH     : width of one fifo word (shared by fifo and arbiter)
//   ARB_N_REQ      : default requester count of fifo_push_arbiter
//   ARB_MAX_BURST  : default beats per ownership of fifo_push_arbiter
//   arb_state_e    : arbiter FSM state (IDLE searches, LOCKED keeps owner)
// ---------------------------------------------------------------------------
package fifo_package;

  localparam int DATA_WIDTH    = 8;

  localparam int ARB_N_REQ     = 4;
  localparam int ARB_MAX_BURST = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_push_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin search: returns the first set bit of req_i at
//   or after start_i, wrapping modulo N_REQ (N_REQ need not be a power of 2).
//   req_i       : request vector
//   start_i     : index with highest priority (must be < N_REQ)
//   sel_o       : selected index (equals start_i when nothing is requested)
//   any_valid_o : at least one request is set
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] sel_o,
  output logic             any_valid_o
);

  always_comb begin
    int idx;
    idx         = 0;
    sel_o       = start_i;
    any_valid_o = |req_i;
    // Walk distances from farthest to nearest so the nearest hit wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(start_i) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (req_i[idx[IDX_W-1:0]]) begin
        sel_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_push_arbiter
//   Round-robin arbiter sharing the fifo push port among N_REQ requesters.
//   A winner keeps ownership for up to MAX_BURST beats so its words stay
//   contiguous in the fifo; afterwards it drops to lowest priority.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   req_valid_i  : per-requester push valid
//   req_data_i   : packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_grant_o  : per-requester grant, one-hot or zero
//   push_data_o  : data to fifo push port
//   push_valid_o : valid to fifo push port
//   push_grant_i : grant from fifo (not full)
//   owner_o      : current owner or selected requester
//   locked_o     : high while a burst owns the port
// ---------------------------------------------------------------------------
module fifo_push_arbiter
  import fifo_package::*;
#(
  parameter int N_REQ      = ARB_N_REQ,
  parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
  parameter int MAX_BURST  = ARB_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_grant_o,
  output logic [DATA_WIDTH-1:0]       push_data_o,
  output logic                        push_valid_o,
  input  logic                        push_grant_i,
  output logic [$clog2(N_REQ)-1:0]    owner_o,
  output logic                        locked_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]      sel;
  logic                  any_valid;
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];

  logic                  push_valid;
  logic [IDX_W-1:0]      owner_sel;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  locked;
  logic                  xfer;
  logic                  release_burst;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(N_REQ - 1)) begin
      return '0;
    end
    return p + IDX_W'(1);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i       (req_valid_i),
    .start_i     (rr_ptr_q),
    .sel_o       (sel),
    .any_valid_o (any_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic
  assign xfer = push_valid && push_grant_i;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    beat_cnt_d    = beat_cnt_q;
    release_burst = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_d = ptr_inc(sel);
          end else begin
            state_d    = ARB_LOCKED;
            owner_d    = sel;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        // A dropped valid ends the burst early; a full fifo just stalls it.
        if (!req_valid_i[owner_q]) begin
          release_burst = 1'b1;
        end else if (push_grant_i) begin
          if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            release_burst = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (release_burst) begin
      state_d    = ARB_IDLE;
      rr_ptr_d   = ptr_inc(owner_q);
      beat_cnt_d = '0;
    end
  end

  // Output logic
  always_comb begin
    push_valid = 1'b0;
    owner_sel  = rr_ptr_q;
    push_data  = '0;
    locked     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        push_valid = any_valid;
        if (any_valid) begin
          owner_sel = sel;
          push_data = data_arr[sel];
        end
      end
      ARB_LOCKED: begin
        push_valid = req_valid_i[owner_q];
        owner_sel  = owner_q;
        push_data  = data_arr[owner_q];
        locked     = 1'b1;
      end
      default: begin
        push_valid = 1'b0;
      end
    endcase

    // Outputs are forced quiet for the whole reset window, not just at the
    // edge, so a requester cannot see a grant while state is being cleared.
    push_valid_o = rst_n && push_valid;
    owner_o      = rst_n ? owner_sel : '0;
    push_data_o  = rst_n ? push_data : '0;
    locked_o     = rst_n && locked;

    req_grant_o = '0;
    if (push_valid_o && push_grant_i) begin
      req_grant_o[owner_o] = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
  import fifo_package::*;

  localparam int DW = DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]      vld;
  logic [DW-1:0]   words [4];
  logic [4*DW-1:0] rdata;
  logic            pgnt;
  always_comb rdata = {words[3], words[2], words[1], words[0]};

  logic [3:0]    gnt0;
  logic [DW-1:0] pd0;
  logic          pv0;
  logic [1:0]    own0;
  logic          lk0;

  logic [2:0]    gnt1;
  logic [DW-1:0] pd1;
  logic          pv1;
  logic [1:0]    own1;
  logic          lk1;

  logic [4:0] pk_req;
  logic [2:0] pk_start;
  logic [2:0] pk_sel;
  logic       pk_any;

  fifo_push_arbiter #(.N_REQ(4), .DATA_WIDTH(DW), .MAX_BURST(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vld), .req_data_i(rdata),
    .req_grant_o(gnt0), .push_data_o(pd0), .push_valid_o(pv0),
    .push_grant_i(pgnt), .owner_o(own0), .locked_o(lk0)
  );

  fifo_push_arbiter #(.N_REQ(3), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vld[2:0]), .req_data_i(rdata[3*DW-1:0]),
    .req_grant_o(gnt1), .push_data_o(pd1), .push_valid_o(pv1),
    .push_grant_i(pgnt), .owner_o(own1), .locked_o(lk1)
  );

  rr_priority_picker #(.N_REQ(5)) u_pick (
    .req_i(pk_req), .start_i(pk_start), .sel_o(pk_sel), .any_valid_o(pk_any)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-arbiter pointer, lock flag, owner and beat count.
  int m_ptr [2];
  int m_lock[2];
  int m_own [2];
  int m_cnt [2];
  int m_n   [2] = '{4, 3};
  int m_mb  [2] = '{4, 1};

  logic       obs_pv [2];
  int         obs_own[2];
  logic [3:0] obs_gnt[2];
  logic       obs_lk [2];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_lock[u] = 0; m_own[u] = 0; m_cnt[u] = 0;
    end
  endtask

  task automatic model_out(input int u, output logic pv, output int ow);
    int j;
    pv = 1'b0;
    ow = m_ptr[u];
    if (m_lock[u] != 0) begin
      j  = m_own[u];
      pv = vld[j[1:0]];
      ow = m_own[u];
    end else begin
      for (int k = 0; k < m_n[u]; k++) begin
        j = (m_ptr[u] + k) % m_n[u];
        if (!pv && vld[j[1:0]]) begin
          pv = 1'b1;
          ow = j;
        end
      end
    end
  endtask

  task automatic model_release(input int u);
    m_lock[u] = 0;
    m_ptr[u]  = (m_own[u] + 1) % m_n[u];
    m_cnt[u]  = 0;
  endtask

  task automatic model_upd(input int u, input logic pv, input int ow);
    if (m_lock[u] != 0) begin
      if (!pv) begin
        model_release(u);
      end else if (pgnt) begin
        m_cnt[u]++;
        if (m_cnt[u] == m_mb[u]) model_release(u);
      end
    end else if (pv && pgnt) begin
      if (m_mb[u] == 1) begin
        m_ptr[u] = (ow + 1) % m_n[u];
      end else begin
        m_lock[u] = 1; m_own[u] = ow; m_cnt[u] = 1;
      end
    end
  endtask

  // One clock: check both arbiters against the model, then advance the model.
  task automatic step();
    logic epv[2];
    int   eow[2];
    #1;
    for (int u = 0; u < 2; u++) begin
      logic [3:0]    g;
      logic [DW-1:0] d;
      logic [DW-1:0] ed;
      logic [3:0]    eg;
      logic          p;
      logic          l;
      int            o;
      if (u == 0) begin
        g = gnt0; d = pd0; p = pv0; o = int'(own0); l = lk0;
      end else begin
        g = {1'b0, gnt1}; d = pd1; p = pv1; o = int'(own1); l = lk1;
      end
      model_out(u, epv[u], eow[u]);
      eg = (epv[u] && pgnt) ? (4'b0001 << eow[u]) : 4'b0000;
      ed = (m_lock[u] != 0 || epv[u]) ? words[eow[u][1:0]] : '0;
      chk($sformatf("u%0d_push_valid", u), int'(p), int'(epv[u]));
      chk($sformatf("u%0d_owner", u), o, eow[u]);
      chk($sformatf("u%0d_grant", u), int'(g), int'(eg));
      chk($sformatf("u%0d_data", u), int'(d), int'(ed));
      chk($sformatf("u%0d_locked", u), int'(l), m_lock[u]);
      obs_pv[u] = p; obs_own[u] = o; obs_gnt[u] = g; obs_lk[u] = l;
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_upd(u, epv[u], eow[u]);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_pv0"}, int'(pv0), 0);
    chk({tag, "_gnt0"}, int'(gnt0), 0);
    chk({tag, "_lk0"}, int'(lk0), 0);
    chk({tag, "_own0"}, int'(own0), 0);
    chk({tag, "_pv1"}, int'(pv1), 0);
    chk({tag, "_gnt1"}, int'(gnt1), 0);
    chk({tag, "_own1"}, int'(own1), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  es;
    logic found;
    rst_n = 1'b0;
    pgnt  = 1'b1;
    vld   = 4'b0100;
    for (int i = 0; i < 4; i++) words[i] = DW'($urandom);
    pk_req = '0;
    pk_start = '0;

    // Standalone picker with 5 inputs (non power of two).
    for (int t = 0; t < 200; t++) begin
      pk_req   = 5'($urandom);
      pk_start = 3'($urandom_range(0, 4));
      #1;
      found = 1'b0;
      es    = 0;
      for (int k = 0; k < 5; k++) begin
        int j;
        j = (int'(pk_start) + k) % 5;
        if (!found && pk_req[j[2:0]]) begin
          found = 1'b1;
          es    = j;
        end
      end
      chk("pick_any", int'(pk_any), int'(found));
      if (found) chk("pick_sel", int'(pk_sel), es);
    end

    // Reset holds outputs quiet whatever the requests are.
    @(negedge clk);
    chk_reset("rst_hold_a");
    vld = 4'b1111;
    chk_reset("rst_hold_b");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // All requesters valid: bursts of 4 in order; MAX_BURST=1 unit rotates.
    for (int i = 0; i < 32; i++) begin
      step();
      chk("rr4_owner", obs_own[0], (i / 4) % 4);
      chk("rr4_grant", int'(obs_gnt[0]), 1 << ((i / 4) % 4));
      chk("rr3_owner", obs_own[1], i % 3);
    end

    // Requester 2 alone for two beats, then drops: bubble then release.
    vld = 4'b0100;
    step(); chk("r2_beat1", int'(obs_gnt[0]), 4);
    step(); chk("r2_beat2", int'(obs_gnt[0]), 4);
    vld = 4'b0000;
    step(); chk("r2_bubble_pv", int'(obs_pv[0]), 0); chk("r2_bubble_lk", int'(obs_lk[0]), 1);
    step(); chk("r2_rel_lk", int'(obs_lk[0]), 0); chk("r2_rel_ptr", obs_own[0], 3);

    // Owner 1 stalls on a full fifo for five cycles, then finishes its burst.
    vld = 4'b0010;
    step(); chk("stall_b1", int'(obs_gnt[0]), 2);
    step(); chk("stall_b2", int'(obs_gnt[0]), 2);
    pgnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_gnt", int'(obs_gnt[0]), 0);
      chk("stall_own", obs_own[0], 1);
      chk("stall_lk", int'(obs_lk[0]), 1);
    end
    pgnt = 1'b1;
    step(); chk("stall_b3", int'(obs_gnt[0]), 2);
    step(); chk("stall_b4", int'(obs_gnt[0]), 2);
    vld = 4'b0000;
    step(); chk("stall_end_lk", int'(obs_lk[0]), 0); chk("stall_end_ptr", obs_own[0], 2);

    // Wrap-around on the per-beat unit: pointer at top index, top and 0 valid.
    vld = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("wrap_own", obs_own[1], (i % 2 == 0) ? 2 : 0);
      chk("wrap_gnt", int'(obs_gnt[1]), (i % 2 == 0) ? 4 : 1);
    end

    // Reset in the middle of a burst by requester 1.
    vld = 4'b0000;
    step();
    vld = 4'b0010;
    step(); chk("mid_b1", int'(obs_gnt[0]), 2);
    step(); chk("mid_b2", int'(obs_gnt[0]), 2);
    rst_n = 1'b0;
    chk_reset("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    vld = 4'b1111;
    step();
    chk("mid_restart_own", obs_own[0], 0);
    chk("mid_restart_gnt", int'(obs_gnt[0]), 1);

    // Randomized traffic; requesters hold valid/data until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vld[i] || obs_gnt[0][i]) begin
          vld[i]   = ($urandom_range(0, 99) < 60);
          words[i] = DW'($urandom);
        end
      end
      pgnt = ($urandom_range(0, 3) != 0);
      if (c % 600 == 599) begin
        rst_n = 1'b0;
        chk_reset("rnd_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares the single push port of the team's fifo block among N_REQ requesters.
- Each requester presents a valid/grant push interface. The arbiter forwards the selected requester's data to the fifo push interface and routes the fifo's grant back to the winner.
- A granted requester keeps ownership for a burst of up to MAX_BURST beats, so that its consecutive words stay contiguous in the FIFO.
- Sits directly upstream of fifo; push_data_o, push_valid_o and push_grant_i connect to fifo's push_data_i, push_valid_i and push_grant_o.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, fifo_package::DATA_WIDTH, width of one data word.
- MAX_BURST, 4, maximum beats per ownership (>=1; 1 means pure per-beat round-robin).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester push valid.
- req_data_i  in  N_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_grant_o  out  N_REQ  per-requester grant; one-hot or zero.
- push_data_o  out  DATA_WIDTH  data to fifo push port.
- push_valid_o  out  1  valid to fifo push port.
- push_grant_i  in  1  grant from fifo (not full).
- owner_o  out  $clog2(N_REQ)  index of current or selected requester.
- locked_o  out  1  high while in the LOCKED state.

Behaviour:
- Transfer occurs when push_valid_o && push_grant_i are high on a rising edge.
- Registered state: state (IDLE/LOCKED), rr_ptr, owner, beat_cnt ($clog2(MAX_BURST+1) bits).
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - While rst_n is low, push_valid_o=0, req_grant_o=0, locked_o=0 and owner_o=0, regardless of inputs.
- IDLE:
  - sel = first i with req_valid_i[i]=1, searching from rr_ptr upward with modulo-N_REQ wrap.
  - push_valid_o = |req_valid_i; push_data_o = data[sel]; owner_o = sel.
  - If no request is valid: push_valid_o=0, push_data_o=0, owner_o=rr_ptr.
  - On transfer with MAX_BURST==1: rr_ptr <= (sel+1) mod N_REQ; state stays IDLE.
  - On transfer with MAX_BURST>1: owner <= sel, beat_cnt <= 1, state <= LOCKED.
- LOCKED:
  - Only the owner is considered. push_valid_o = req_valid_i[owner]; push_data_o = data[owner]; owner_o = owner; locked_o = 1.
  - On transfer: beat_cnt increments. If the new count equals MAX_BURST, then state <= IDLE, rr_ptr <= (owner+1) mod N_REQ, beat_cnt <= 0.
  - If req_valid_i[owner]=0 at an edge: release. State <= IDLE, rr_ptr <= (owner+1) mod N_REQ, beat_cnt <= 0. That cycle is a bubble (push_valid_o=0).
  - If the owner is valid but push_grant_i=0 (fifo full): hold, no count change. There is no timeout; the fifo drains eventually.
- Grants:
  - req_grant_o[i] = push_valid_o && push_grant_i && (owner_o==i), combinational.
  - Zero-cycle latency from push_grant_i to req_grant_o.
  - A requester must hold valid and data stable until granted.
- Fairness: after any ownership ends, the previous owner has the lowest priority. No requester waits longer than (N_REQ-1)*MAX_BURST transfers once it asserts valid.
- Wrap-around: the search from rr_ptr=N_REQ-1 continues at index 0.
- All pointer arithmetic is modulo N_REQ and must be correct for non-power-of-2 N_REQ.
- Simultaneous events:
  - A transfer completing MAX_BURST while other requesters are valid goes to IDLE. The next winner is chosen in the following cycle, with no extra bubble beyond the state change.
  - A requester dropping valid in the same cycle it is granted is legal: the beat transfers and the next edge releases.
- Reset mid-burst: all state clears immediately. An in-flight beat whose edge coincides with reset assertion is not counted.

Decomposition:
- fifo_package gains: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e; constants ARB_N_REQ=4 and ARB_MAX_BURST=4. DATA_WIDTH is reused from the package.
- One sub-module, rr_priority_picker: combinational. Inputs are the req vector and a start pointer; outputs are sel index and any_valid. It is instanced once and unit-tested separately.

Test Plan:
- Reset: rst_n=0 with req_valid_i=4'b1111 -> push_valid_o=0, req_grant_o=0. After release, the first grant goes to requester 0.
- All 4 requesters continuously valid, push_grant_i=1, MAX_BURST=4 -> grant order is 0x4 beats, 1x4, 2x4, 3x4, 0... Data in the fifo is contiguous per requester.
- Requester 2 only, valid for 2 beats then drops -> 2 transfers, one bubble cycle, locked_o falls, rr_ptr=3.
- Owner 1 mid-burst with push_grant_i=0 for 5 cycles -> no grants, beat_cnt frozen at its value, owner unchanged. Burst completes after the grant returns.
- Requesters 3 and 0 valid, rr_ptr=3, MAX_BURST=1 -> alternating grants 3,0,3,0 (wrap-around check).
- rst_n asserted after beat 2 of a burst by requester 1 -> outputs zero immediately; after release, arbitration restarts from requester 0.
